// File: rtl/router_port_arbiter_pkg.sv
// Shared flit-format definitions and arbiter state type for the router output-port allocator.
package router_port_arbiter_pkg;

  localparam int unsigned FLIT_WIDTH  = 32;
  localparam int unsigned FLIT_TYPE_W = 2;

  // Flit type lives in the top FLIT_TYPE_W bits of every flit.
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b10;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b01;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic {
    StIdle,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/router_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + 1 + k) % int'(N)))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = IdxW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/router_port_arbiter.sv
// Output-port allocator: round-robin pick, wormhole lock from HEAD to TAIL, registered flit output.
module router_port_arbiter
  import router_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = FLIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA_IN,
  input  logic [NUM_REQ-1:0]            REQ_VALID_IN,
  output logic [NUM_REQ-1:0]            REQ_POP_OUT,
  output logic [DATA_WIDTH-1:0]         DATA_OUT,
  output logic                          DATA_VALID_OUT,
  input  logic                          FULL_IN,
  output logic [NUM_REQ-1:0]            GRANT_OUT,
  output logic                          ERR_OUT
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  arb_state_e state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IdxW-1:0]       arb_idx;
  logic [IdxW-1:0]       cand;
  logic                  cand_vld;
  logic                  fire;
  logic [DATA_WIDTH-1:0] cand_data;
  logic [FLIT_TYPE_W-1:0] cand_type;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req (REQ_VALID_IN),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    if (state_q == StLocked) begin
      cand     = owner_q;
      cand_vld = REQ_VALID_IN[owner_q];
    end else begin
      cand     = arb_idx;
      cand_vld = |arb_gnt;
    end
    // No dequeue while reset is held so every output reads zero during reset.
    fire      = cand_vld & ~FULL_IN & rst_n;
    cand_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cand == IdxW'(i)) cand_data = REQ_DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
    cand_type = cand_data[DATA_WIDTH-1 -: FLIT_TYPE_W];
  end

  always_comb begin
    REQ_POP_OUT = '0;
    GRANT_OUT   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cand == IdxW'(i)) REQ_POP_OUT[i] = fire;
      if ((state_q == StLocked) && (owner_q == IdxW'(i))) GRANT_OUT[i] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    if (fire) begin
      data_d  = cand_data;
      valid_d = 1'b1;
      case (state_q)
        StIdle: begin
          if (cand_type == FLIT_HEAD) begin
            state_d = StLocked;
            owner_d = cand;
          end else begin
            // Stray BODY/TAIL is forwarded like a SINGLE but flagged.
            rr_ptr_d = cand;
            if (cand_type != FLIT_SINGLE) err_d = 1'b1;
          end
        end
        StLocked: begin
          if (cand_type == FLIT_TAIL) begin
            state_d  = StIdle;
            rr_ptr_d = owner_q;
          end else if (cand_type != FLIT_BODY) begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= LastIdx;
      owner_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign DATA_OUT       = data_q;
  assign DATA_VALID_OUT = valid_q;
  assign ERR_OUT        = err_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter with NUM_REQ=4, DATA_WIDTH=32.
module tb_router_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   d [NR];
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_valid = '0;
  logic            full = 1'b0;
  logic [NR-1:0]   pop;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic [NR-1:0]   grant;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign req_data = {d[3], d[2], d[1], d[0]};

  router_port_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .REQ_DATA_IN    (req_data),
    .REQ_VALID_IN   (req_valid),
    .REQ_POP_OUT    (pop),
    .DATA_OUT       (data_out),
    .DATA_VALID_OUT (data_valid),
    .FULL_IN        (full),
    .GRANT_OUT      (grant),
    .ERR_OUT        (err)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    full = 1'b0;
    for (int i = 0; i < NR; i++) d[i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      req_valid = NR'($urandom);
      full = 1'($urandom);
      for (int i = 0; i < NR; i++) d[i] = $urandom;
      #2;
      n_checks++;
      if ({pop, grant, data_out, data_valid, err} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: pop=%b grant=%b data=%h valid=%b err=%b, want all 0",
                 r, pop, grant, data_out, data_valid, err);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    full = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) d[i] = 32'hC000_0000 + i;
    @(negedge clk);
    n_checks++;
    if (pop !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_pop: got %b want 0001", pop);
    end
    @(posedge clk); #1;
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hC000_0000) begin
      n_fail++;
      $display("FAIL reset_first_data: got valid=%b data=%h want 1/c0000000", data_valid, data_out);
    end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) d[i] = 32'hC000_0000 + i;
    for (int c = 0; c < 6; c++) begin
      e = c % 4;
      @(negedge clk);
      n_checks++;
      if (pop !== NR'(1 << e) || grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_pop[%0d]: got pop=%b grant=%b want pop=%b grant=0000",
                 c, pop, grant, NR'(1 << e));
      end
      @(posedge clk); #1;
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 32'hC000_0000 + e) begin
        n_fail++;
        $display("FAIL rr_data[%0d]: got valid=%b data=%h want 1/%h",
                 c, data_valid, data_out, 32'hC000_0000 + e);
      end
    end
  endtask

  task automatic test_wormhole();
    logic [3:0]  t_vld [6];
    logic [31:0] t_d1  [6];
    logic [3:0]  t_pop [6];
    logic [3:0]  t_gnt [6];
    logic        t_ov  [6];
    logic [31:0] t_od  [6];
    t_vld = '{4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b1000};
    t_d1  = '{32'h8000_0011, 32'h0000_0012, 32'h0000_0012, 32'h0000_0013, 32'h4000_0014,
              32'h4000_0014};
    t_pop = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1000};
    t_gnt = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    t_ov  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t_od  = '{32'h8000_0011, 32'h0000_0012, 32'h0000_0012, 32'h0000_0013, 32'h4000_0014,
              32'hC000_0033};
    do_reset();
    d[3] = 32'hC000_0033;
    for (int c = 0; c < 6; c++) begin
      req_valid = t_vld[c];
      d[1] = t_d1[c];
      @(negedge clk);
      n_checks++;
      if (pop !== t_pop[c] || grant !== t_gnt[c]) begin
        n_fail++;
        $display("FAIL wh_pop[%0d]: got pop=%b grant=%b want pop=%b grant=%b",
                 c, pop, grant, t_pop[c], t_gnt[c]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (data_valid !== t_ov[c] || data_out !== t_od[c]) begin
        n_fail++;
        $display("FAIL wh_data[%0d]: got valid=%b data=%h want %b/%h",
                 c, data_valid, data_out, t_ov[c], t_od[c]);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wh_err: got %b want 0", err);
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0]  t_vld  [8];
    logic        t_full [8];
    logic [31:0] t_d2   [8];
    logic [3:0]  t_pop  [8];
    logic [3:0]  t_gnt  [8];
    logic        t_ov   [8];
    logic [31:0] t_od   [8];
    t_vld  = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001};
    t_full = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_d2   = '{32'h8000_0021, 32'h0000_0022, 32'h0000_0022, 32'h0000_0022, 32'h0000_0022,
               32'h0000_0023, 32'h4000_0024, 32'h4000_0024};
    t_pop  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    t_gnt  = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    t_ov   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_od   = '{32'h8000_0021, 32'h8000_0021, 32'h8000_0021, 32'h8000_0021, 32'h0000_0022,
               32'h0000_0023, 32'h4000_0024, 32'hC000_0001};
    do_reset();
    d[0] = 32'hC000_0001;
    for (int c = 0; c < 8; c++) begin
      req_valid = t_vld[c];
      full = t_full[c];
      d[2] = t_d2[c];
      @(negedge clk);
      n_checks++;
      if (pop !== t_pop[c] || grant !== t_gnt[c]) begin
        n_fail++;
        $display("FAIL bp_pop[%0d]: got pop=%b grant=%b want pop=%b grant=%b",
                 c, pop, grant, t_pop[c], t_gnt[c]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (data_valid !== t_ov[c] || data_out !== t_od[c]) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got valid=%b data=%h want %b/%h",
                 c, data_valid, data_out, t_ov[c], t_od[c]);
      end
    end
    full = 1'b0;
  endtask

  task automatic test_protocol_errors();
    logic [3:0]  t_vld [6];
    logic [31:0] t_d1  [6];
    logic [3:0]  t_pop [6];
    logic [3:0]  t_gnt [6];
    logic [31:0] t_od  [6];
    t_vld = '{4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
    t_d1  = '{32'h0, 32'h8000_0006, 32'h8000_0007, 32'h0000_0008, 32'h4000_0009, 32'h4000_0009};
    t_pop = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    t_gnt = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    t_od  = '{32'h0000_0005, 32'h8000_0006, 32'h8000_0007, 32'h0000_0008, 32'h4000_0009,
              32'h0000_0005};
    do_reset();
    d[0] = 32'h0000_0005;
    for (int c = 0; c < 6; c++) begin
      req_valid = t_vld[c];
      d[1] = t_d1[c];
      @(negedge clk);
      n_checks++;
      if (pop !== t_pop[c] || grant !== t_gnt[c]) begin
        n_fail++;
        $display("FAIL perr_pop[%0d]: got pop=%b grant=%b want pop=%b grant=%b",
                 c, pop, grant, t_pop[c], t_gnt[c]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== t_od[c] || err !== 1'b1) begin
        n_fail++;
        $display("FAIL perr_data[%0d]: got valid=%b data=%h err=%b want 1/%h/1",
                 c, data_valid, data_out, err, t_od[c]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_valid = 4'b1000;
    d[3] = 32'h0000_0077;
    @(negedge clk);
    n_checks++;
    if (pop !== 4'b1000) begin
      n_fail++;
      $display("FAIL rmp_body_pop: got %b want 1000", pop);
    end
    @(posedge clk); #1;
    req_valid = 4'b0100;
    d[2] = 32'h8000_0002;
    @(posedge clk); #1;
    n_checks++;
    if (grant !== 4'b0100 || err !== 1'b1 || data_out !== 32'h8000_0002) begin
      n_fail++;
      $display("FAIL rmp_locked: got grant=%b err=%b data=%h want 0100/1/80000002",
               grant, err, data_out);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pop, grant, data_out, data_valid, err} !== '0) begin
      n_fail++;
      $display("FAIL rmp_reset: pop=%b grant=%b data=%h valid=%b err=%b, want all 0",
               pop, grant, data_out, data_valid, err);
    end
    rst_n = 1'b1;
    req_valid = 4'b0101;
    d[0] = 32'hC000_00A0;
    d[2] = 32'hC000_00A2;
    @(negedge clk);
    n_checks++;
    if (pop !== 4'b0001 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmp_first_pop: got pop=%b grant=%b want 0001/0000", pop, grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hC000_00A0) begin
      n_fail++;
      $display("FAIL rmp_first_data: got %b/%h want 1/c00000a0", data_valid, data_out);
    end
    @(negedge clk);
    n_checks++;
    if (pop !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmp_second_pop: got %b want 0100", pop);
    end
    @(posedge clk); #1;
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hC000_00A2) begin
      n_fail++;
      $display("FAIL rmp_second_data: got %b/%h want 1/c00000a2", data_valid, data_out);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) d[i] = '0;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_back_pressure();
    test_protocol_errors();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Output-port allocator for one router output (LOCAL, X, X1, X2 or Y).
- Each router input FIFO presents its head flit when it is routed to this port. The block picks one requester with round-robin priority and holds that choice for a whole wormhole packet (head to tail).
- It registers the selected flit onto the port's DATA/VALID pair and obeys the downstream FULL back-pressure.
- A router_border / router_normal instance uses one of these per output port.

Parameters:
- NUM_REQ, 4, number of requesting input ports (router_border uses 3, router_normal uses 4).
- DATA_WIDTH, `DATA_WIDTH (32), flit width. The top 2 bits are the flit type.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- REQ_DATA_IN  in  NUM_REQ*DATA_WIDTH  head flit of each input FIFO; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_VALID_IN  in  NUM_REQ  requester i has a flit for this port (FIFO non-empty and routed here).
- REQ_POP_OUT  out  NUM_REQ  one-hot combinational dequeue strobe to input FIFO i.
- DATA_OUT  out  DATA_WIDTH  registered flit to the downstream router or PE.
- DATA_VALID_OUT  out  1  one-cycle pulse per flit.
- FULL_IN  in  1  downstream buffer almost-full; it must be asserted with at least one free slot left.
- GRANT_OUT  out  NUM_REQ  one-hot current packet owner; zero when IDLE.
- ERR_OUT  out  1  sticky protocol-error flag.

Behaviour:
- Flit type field is DATA[DATA_WIDTH-1:DATA_WIDTH-2]:
  - 2'b10 = HEAD
  - 2'b00 = BODY
  - 2'b01 = TAIL
  - 2'b11 = SINGLE
- Reset values:
  - All outputs 0.
  - state = IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 has highest priority after reset.
- Candidate selection:
  - IDLE: the first i with REQ_VALID_IN[i], searching from rr_ptr+1 upward with wrap.
  - LOCKED: only the owner.
- fire = candidate exists & REQ_VALID_IN[cand] & !FULL_IN.
- REQ_POP_OUT[cand] = fire, in the same cycle. Never more than one bit is set.
- On fire: DATA_OUT <= REQ_DATA_IN[cand] and DATA_VALID_OUT <= 1 at the next edge, giving 1-cycle latency.
- No fire: DATA_VALID_OUT <= 0 and DATA_OUT holds its previous value.
- FULL_IN high: no pop and no output. Priority and ownership are unchanged, and the packet stays locked.
- FSM IDLE, on fire:
  - SINGLE: stay IDLE; rr_ptr <= cand.
  - HEAD: go LOCKED; owner <= cand.
  - BODY or TAIL: forward the flit as if SINGLE; ERR_OUT <= 1; rr_ptr <= cand.
- FSM LOCKED, on fire:
  - BODY: stay LOCKED.
  - TAIL: go IDLE; rr_ptr <= owner, so the owner becomes lowest priority.
  - HEAD or SINGLE: forward; ERR_OUT <= 1; stay LOCKED.
- LOCKED with the owner's REQ_VALID_IN low (bubble): wait. Other requesters are never granted mid-packet.
- GRANT_OUT:
  - LOCKED: owner one-hot.
  - IDLE: 0.
- Simultaneous requests: only round-robin order decides; exactly one requester fires per cycle.
- A new packet may start in the cycle after a TAIL fires. Back-to-back SINGLE flits sustain 1 flit/cycle.
- rst_n low mid-packet: immediately go IDLE, clear outputs and ERR_OUT, rr_ptr = NUM_REQ-1. The partial packet downstream is the upstream's responsibility.

Decomposition:
- Shared header router_defs.vh holds:
  - `DATA_WIDTH
  - flit-type localparams FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE
  - the type-field position macros
- One combinational sub-module, rr_arbiter (parameter N; inputs req[N] and ptr; outputs one-hot gnt and idx), instanced once.
- The FSM, the output register, rr_ptr and the owner register live in router_port_arbiter.

Test Plan (NUM_REQ=4, DATA_WIDTH=32):
- Reset check: drive rst_n low with random inputs → all outputs 0. Release, then REQ_VALID_IN=4'b1111 with SINGLE flits → first grant to requester 0.
- Round-robin order: all four requesters hold SINGLE flits continuously → DATA_VALID_OUT high every cycle; pop order 0,1,2,3,0,1; DATA_OUT matches each requester's data (e.g. 0xC0000000+i).
- Wormhole lock: req1 sends HEAD, BODY, bubble, BODY, TAIL while req3 holds a SINGLE → req3 is not popped until the cycle after req1's TAIL fires. GRANT_OUT=4'b0010 throughout the packet. Output shows 4 req1 flits then the req3 flit.
- Back-pressure: FULL_IN high for 3 cycles during a locked packet → REQ_POP_OUT=0 and DATA_VALID_OUT=0 for those cycles. Resumes on the cycle FULL_IN drops, with no flit lost or duplicated.
- Protocol errors: a BODY flit while IDLE → forwarded, ERR_OUT=1 and sticky. A HEAD inside a locked packet → forwarded, still LOCKED.
- Reset mid-packet: assert rst_n after req2's HEAD → state IDLE. After release, req0 and req2 both request SINGLE → req0 wins first.
